// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter. It holds a grant for one packet, then forces a one-cycle idle gap.
// Optional forced release after TIMEOUT clocks is built when ROUTER_ARB_TIMEOUT_EN is defined.
module router_out_arbiter #(
    parameter  int NPORTS  = 16,
    parameter  int TIMEOUT = 256,
    localparam int IDW     = $clog2(NPORTS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NPORTS-1:0] req,
    input  logic              pkt_done,
    output logic [NPORTS-1:0] gnt,
    output logic [IDW-1:0]    gnt_id,
    output logic              busy,
    output logic              timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t            state_q, state_d;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]    gnt_id_q, gnt_id_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    win_id, idx;
    logic              win_found;
    logic              to_hit;
    logic              rel;

    // Search starts at last+1 and wraps; the final step (i == NPORTS) lands back on last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = last_q + IDW'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q;

    // A pkt_done on the terminal cycle wins, so the release counts as normal.
    always_comb begin
        cnt_d  = cnt_q;
        to_hit = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1)) && !pkt_done;
        if (state_q == GRANT) cnt_d = cnt_q + CW'(1);
        else                  cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= to_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        rel      = pkt_done | to_hit;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d       = GRANT;
                    gnt_d         = '0;
                    gnt_d[win_id] = 1'b1;
                    gnt_id_d      = win_id;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = HOLDOFF;
                    gnt_d   = '0;
                    last_d  = gnt_id_q;
                end
            end
            HOLDOFF: state_d = IDLE;
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= IDW'(NPORTS - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: vector table, corner sequences, random run vs reference model.
module tb_router_out_arbiter;
    localparam int N  = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          pkt_done = 1'b0;
    logic [N-1:0]  gnt;
    logic [3:0]    gnt_id;
    logic          busy;
    logic          timeout;

    int checks = 0;
    int failures = 0;

    router_out_arbiter #(.NPORTS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pkt_done(pkt_done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 granted, 2 gap cycle.
    int m_phase, m_owner, m_last, m_age;
    bit m_to;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = N - 1; m_age = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic pd);
        bit release_now;
        m_to = 0;
        if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (r[p] && m_phase == 0) begin
                    m_phase = 1; m_owner = p; m_age = 1;
                end
            end
        end else if (m_phase == 1) begin
            release_now = pd;
`ifdef ROUTER_ARB_TIMEOUT_EN
            // grant has been visible for m_age cycles; the TIMEOUT-th cycle is the last
            if (!pd && m_age == TO) begin
                release_now = 1; m_to = 1;
            end
`endif
            if (release_now) begin
                m_phase = 2; m_last = m_owner;
            end else begin
                m_age++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_phase == 1) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic pd);
        req = r;
        pkt_done = pd;
        @(posedge clk);
        model_edge(r, pd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        pkt_done = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic         pd;
        logic [N-1:0] e_gnt;
        logic [3:0]   e_id;
        logic         e_busy;
    } vec_t;

    vec_t vecs[22];
    bit   held_ok;

    initial begin
        // single request, mid-packet drop, idle pkt_done, wrap and skip
        vecs[0]  = '{16'h0020, 1'b0, 16'h0020, 4'd5,  1'b1};
        vecs[1]  = '{16'h0000, 1'b1, 16'h0000, 4'd5,  1'b1};
        vecs[2]  = '{16'h0000, 1'b0, 16'h0000, 4'd5,  1'b0};
        vecs[3]  = '{16'h0004, 1'b0, 16'h0004, 4'd2,  1'b1};
        vecs[4]  = '{16'h0003, 1'b0, 16'h0004, 4'd2,  1'b1};
        vecs[5]  = '{16'h0003, 1'b0, 16'h0004, 4'd2,  1'b1};
        vecs[6]  = '{16'h0003, 1'b1, 16'h0000, 4'd2,  1'b1};
        vecs[7]  = '{16'h0000, 1'b0, 16'h0000, 4'd2,  1'b0};
        vecs[8]  = '{16'h0000, 1'b1, 16'h0000, 4'd2,  1'b0};
        vecs[9]  = '{16'h0000, 1'b0, 16'h0000, 4'd2,  1'b0};
        vecs[10] = '{16'h8000, 1'b0, 16'h8000, 4'd15, 1'b1};
        vecs[11] = '{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1};
        vecs[12] = '{16'h4008, 1'b0, 16'h0000, 4'd15, 1'b0};
        vecs[13] = '{16'h4008, 1'b0, 16'h0008, 4'd3,  1'b1};
        vecs[14] = '{16'h4008, 1'b1, 16'h0000, 4'd3,  1'b1};
        vecs[15] = '{16'h4008, 1'b0, 16'h0000, 4'd3,  1'b0};
        vecs[16] = '{16'h4008, 1'b0, 16'h4000, 4'd14, 1'b1};
        vecs[17] = '{16'h0000, 1'b1, 16'h0000, 4'd14, 1'b1};
        vecs[18] = '{16'h0008, 1'b0, 16'h0000, 4'd14, 1'b0};
        vecs[19] = '{16'h0008, 1'b0, 16'h0008, 4'd3,  1'b1};
        vecs[20] = '{16'h0000, 1'b1, 16'h0000, 4'd3,  1'b1};
        vecs[21] = '{16'h0000, 1'b0, 16'h0000, 4'd3,  1'b0};

        do_reset();
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_id", 32'(gnt_id), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].r, vecs[i].pd);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
            check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].e_id));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_to", i), 32'(timeout), 32'h0);
        end

        // asynchronous reset while port 7 holds the grant
        do_reset();
        step(16'h0080, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h0080);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_id", 32'(gnt_id), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(16'hFFFF, 1'b0);
        check("post_rst_first", 32'(gnt), 32'h0001);
        step(16'hFFFF, 1'b1);
        step(16'hFFFF, 1'b0);

        // rotation with all ports requesting: 0..15 then 0, gap of exactly two cycles
        do_reset();
        for (int n = 0; n <= N; n++) begin
            logic [N-1:0] eg;
            eg = '0;
            eg[n % N] = 1'b1;
            step(16'hFFFF, 1'b0);
            check($sformatf("rot%0d_gnt", n), 32'(gnt), 32'(eg));
            check($sformatf("rot%0d_id", n), 32'(gnt_id), 32'(n % N));
            step(16'hFFFF, 1'b0);
            step(16'hFFFF, 1'b0);
            check($sformatf("rot%0d_hold", n), 32'(gnt), 32'(eg));
            step(16'hFFFF, 1'b1);
            check($sformatf("rot%0d_gap1", n), 32'(gnt), 32'h0);
            step(16'hFFFF, 1'b0);
            check($sformatf("rot%0d_gap2", n), 32'(gnt), 32'h0);
        end

        // long grant on port 9 with no pkt_done
        do_reset();
        step(16'h0200, 1'b0);
        check("long_grant", 32'(gnt), 32'h0200);
`ifdef ROUTER_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            step(16'h0200, 1'b0);
            check($sformatf("to_hold%0d", c), 32'(gnt), 32'h0200);
            check($sformatf("to_quiet%0d", c), 32'(timeout), 32'h0);
        end
        step(16'h0200, 1'b0);
        check("to_release_gnt", 32'(gnt), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_last", 32'(gnt_id), 32'h9);
        step(16'h0000, 1'b0);
        check("to_pulse_end", 32'(timeout), 32'h0);
        check("to_idle_busy", 32'(busy), 32'h0);
`else
        held_ok = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            step(16'h0200, 1'b0);
            if (gnt !== 16'h0200 || timeout !== 1'b0) held_ok = 1'b0;
        end
        check("no_to_held_1000", 32'(held_ok), 32'h1);
        check("no_to_gnt", 32'(gnt), 32'h0200);
        step(16'h0200, 1'b1);
        check("no_to_release", 32'(gnt), 32'h0);
`endif

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] r;
            logic         pd;
            r  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
            pd = ($urandom_range(0, 4) == 0);
            step(r, pd);
            check("rnd_gnt", 32'(gnt), 32'(m_gnt()));
            check("rnd_busy", 32'(busy), 32'(m_phase != 0));
            check("rnd_to", 32'(timeout), 32'(m_to));
            if (m_phase == 1) check("rnd_id", 32'(gnt_id), 32'(m_owner));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary, expected completion before 2000000");
        $fatal(1);
    end
endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port round-robin arbiter for the 16x16 serial router. It decides which of the `NPORTS` input ports may drive one output port's `dout`/`frameo_n`/`valido_n` lane. It holds that grant for a whole packet, then releases the output for a one-cycle idle gap. One instance is built per output port, and its `gnt` vector drives the crossbar select for that lane.

## Interface
Parameters:
- `NPORTS`, default 16: number of requesting input ports. Power of two, 2..16.
- `TIMEOUT`, default 256: maximum grant length in clocks. Used only when the timeout feature is compiled in (see Configuration).

Ports:
- `clk`, input, 1: router clock. All state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req`, input, `NPORTS`: level request, one bit per input port. High while that port has a packet decoded for this output.
- `pkt_done`, input, 1: single-cycle pulse from the datapath when the last payload bit has been transferred (`frameo_n` rising).
- `gnt`, output, `NPORTS`: one-hot grant, registered. All zeros when no grant is active.
- `gnt_id`, output, `$clog2(NPORTS)`: binary index of the granted port, registered. Holds its value after release.
- `busy`, output, 1: high when the state is not IDLE.
- `timeout`, output, 1: one-cycle pulse on a forced release.

## Operation
State machine, one-hot or binary encoding:
- **IDLE**
  - No request: stay in IDLE.
  - Any `req` bit high at a clock edge: go to GRANT; `gnt` and `gnt_id` take the winner at that edge.
- **GRANT**
  - `pkt_done` sampled high: go to HOLDOFF; `gnt` goes to 0; pointer `last` is loaded with `gnt_id`.
  - Otherwise: stay in GRANT.
- **HOLDOFF**
  - Always go to IDLE on the next edge. This guarantees `frameo_n` is high for at least one cycle between packets.

Winner selection:
- Round-robin search over `req`, starting at `last+1` and wrapping modulo `NPORTS` through to `last`.
- The first set bit in that order wins.
- `last` resets to `NPORTS-1`, so port 0 has top priority after reset.

Grant lifetime:
- A grant is held until `pkt_done`, regardless of the granted port's `req`. A request that drops mid-packet does not release the grant.
- `pkt_done` sampled in IDLE or HOLDOFF is ignored.
- `req` changes during GRANT or HOLDOFF do not affect the current grant.
- Exactly zero or one bit of `gnt` is ever high.

## Timing
Reset values (applied asynchronously on `reset_n` low):
- State = IDLE.
- `gnt` = 0, `gnt_id` = 0, `busy` = 0, `timeout` = 0, `last` = `NPORTS-1`.
- A reset during GRANT drops `gnt` immediately, without waiting for a clock edge.

Latency and gaps:
- Request to grant: `req` high before edge E while in IDLE gives `gnt` valid after E (1 cycle).
- Release: `pkt_done` sampled at edge E gives `gnt`=0 after E, HOLDOFF from E to E+1, IDLE at E+1. The earliest next grant is after edge E+2.
- Back-to-back packets therefore have `gnt` low for exactly 2 clock periods.
- `busy` is derived from the state register with no combinational path from `req`.

## Configuration
Macro `ROUTER_ARB_TIMEOUT_EN`:
- **Defined:**
  - A counter clears on entry to GRANT and increments each cycle in GRANT.
  - If it reaches `TIMEOUT-1` with no `pkt_done`, the next edge behaves exactly as a `pkt_done`: go to HOLDOFF, `gnt`=0, `last`=`gnt_id`, and `timeout` pulses high for 1 cycle.
  - If `pkt_done` and the terminal count occur in the same cycle, treat it as a normal release with `timeout` = 0.
- **Not defined:**
  - No counter is built.
  - `timeout` is tied to 0.
  - A grant can be held indefinitely.

## Test plan
- **Reset:** assert `reset_n`=0 mid-grant (port 7 granted) → `gnt`=0, `gnt_id`=0, `busy`=0 with no clock edge; after release, `req`=16'hFFFF → port 0 granted first.
- **Single request:** `req`=16'h0020 in IDLE → after 1 edge `gnt`=16'h0020, `gnt_id`=5, `busy`=1. `pkt_done` pulse → `gnt`=0 after the next edge; `busy`=0 two edges after `pkt_done`.
- **Rotation:** `req`=16'hFFFF held, `pkt_done` pulsed 3 cycles after each grant → `gnt_id` sequence 0,1,…,15,0, each grant separated by exactly 2 cycles of `gnt`=0.
- **Wrap and skip:** after port 15 is served, `req`=16'h4008 → grant port 3, then port 14. Then `req`=16'h0008 only → port 3 again (sole requester).
- **Mid-packet request drop:** port 2 granted, `req[2]` drops while other requests stay high, no `pkt_done` → `gnt` stays 16'h0004 until `pkt_done`; `pkt_done` sampled while IDLE → no state change.
- **Timeout (macro defined, `TIMEOUT`=8):** grant port 9 with no `pkt_done` → `gnt` drops after 8 cycles of grant and `timeout` is high for 1 cycle. Without the macro, `gnt` is still 16'h0200 after 1000 cycles.
